// File: rtl/ssram_arbiter_pkg.sv
// Shared definitions for the two-requester SSRAM burst arbiter.
package ssram_arbiter_pkg;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/ssram_port_arbiter_if.sv
// Requester and SSRAM-port signals of the burst arbiter; slave = arbiter side.
interface ssram_port_arbiter_if
  import ssram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
);
  logic                  req0, req1, we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [LEN_W-1:0]      len0, len1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  grant0, grant1, ack0, ack1;
  logic                  rvalid0, rvalid1, done0, done1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] ramAddress;
  logic                  ramWriteEnable;
  logic [DATA_WIDTH-1:0] ramDataIn, ramDataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1, ramDataOut,
    output grant0, grant1, ack0, ack1, rvalid0, rvalid1, done0, done1, rdata,
           ramAddress, ramWriteEnable, ramDataIn
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1, ramDataOut,
    input  grant0, grant1, ack0, ack1, rvalid0, rvalid1, done0, done1, rdata,
           ramAddress, ramWriteEnable, ramDataIn
  );
endinterface

// File: rtl/ssram_rr_pick.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
module ssram_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic lastGrant,
  output logic winner,
  output logic valid
);
  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~lastGrant : req1;
endmodule

// File: rtl/ssram_port_arbiter.sv
// Arbitrates two burst requesters onto one SSRAM port (1-cycle registered read data).
module ssram_port_arbiter
  import ssram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input logic                 clock,
  input logic                 nReset,
  ssram_port_arbiter_if.slave bus
);
  state_t                state, stateNxt;
  logic                  owner, dir, lastGrant, rdPend;
  logic                  winner, pickValid;
  logic [ADDR_WIDTH-1:0] addrCnt, addrHold;
  logic [LEN_W-1:0]      beatCnt;

  ssram_rr_pick u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .lastGrant (lastGrant),
    .winner    (winner),
    .valid     (pickValid)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNxt;
  end

  // Burst context is captured only in IDLE, so requester changes mid-burst are ignored.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      owner     <= 1'b0;
      dir       <= 1'b0;
      lastGrant <= 1'b1;
      addrCnt   <= '0;
      beatCnt   <= '0;
      addrHold  <= '0;
      rdPend    <= 1'b0;
    end else begin
      rdPend <= (state == BURST) && !dir;
      if (state == IDLE && pickValid) begin
        owner     <= winner;
        lastGrant <= winner;
        dir       <= winner ? bus.we1   : bus.we0;
        addrCnt   <= winner ? bus.addr1 : bus.addr0;
        beatCnt   <= winner ? bus.len1  : bus.len0;
      end else if (state == BURST) begin
        addrCnt  <= addrCnt + 1'b1;
        beatCnt  <= beatCnt - 1'b1;
        addrHold <= addrCnt;
      end
    end
  end

  always_comb begin
    stateNxt           = state;
    bus.grant0         = 1'b0;
    bus.grant1         = 1'b0;
    bus.ack0           = 1'b0;
    bus.ack1           = 1'b0;
    bus.done0          = 1'b0;
    bus.done1          = 1'b0;
    bus.ramWriteEnable = 1'b0;
    bus.ramDataIn      = '0;
    case (state)
      IDLE: if (pickValid) stateNxt = BURST;
      BURST: begin
        bus.grant0         = !owner;
        bus.grant1         = owner;
        bus.ack0           = dir && !owner;
        bus.ack1           = dir && owner;
        bus.ramWriteEnable = dir;
        bus.ramDataIn      = owner ? bus.wdata1 : bus.wdata0;
        if (beatCnt == '0) stateNxt = DRAIN;
      end
      DRAIN: begin
        bus.done0 = !owner;
        bus.done1 = owner;
        stateNxt  = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Address holds the last burst address while the port is idle.
  assign bus.ramAddress = (state == BURST) ? addrCnt : addrHold;
  assign bus.rvalid0    = rdPend && !owner;
  assign bus.rvalid1    = rdPend && owner;
  assign bus.rdata      = rdPend ? bus.ramDataOut : '0;
endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Directed bench for ssram_port_arbiter with a behavioural SSRAM model.
module tb_ssram_port_arbiter;
  localparam int NOBS = 24;

  logic clock  = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  ssram_port_arbiter_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();
  ssram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  logic [31:0] mem [512];
  always @(posedge clock) begin
    if (bus.ramWriteEnable) mem[bus.ramAddress] <= bus.ramDataIn;
    bus.ramDataOut <= mem[bus.ramAddress];
  end

  int checks = 0;
  int failures = 0;

  logic        oG0[NOBS], oG1[NOBS], oA0[NOBS], oA1[NOBS];
  logic        oV0[NOBS], oV1[NOBS], oD0[NOBS], oD1[NOBS], oWe[NOBS];
  logic [8:0]  oAd[NOBS];
  logic [31:0] oRd[NOBS];

  always @(negedge clock) begin
    if (nReset) begin
      checks++;
      if (bus.grant0 && bus.grant1) begin
        failures++;
        $display("FAIL grant_mutex t=%0t got=%b%b exp=at most one", $time, bus.grant0, bus.grant1);
      end
    end
  end

  // Issues one burst, records outputs per cycle (index 0 = request cycle), feeds write beats on ack.
  task automatic run_burst(input int who, input logic we, input logic [8:0] a, input logic [3:0] l,
                           input int holdCyc, input logic [31:0] wbase, input int ncyc);
    int beat;
    beat = 0;
    @(posedge clock); #1;
    if (who == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.len0 = l; bus.wdata0 = wbase;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.len1 = l; bus.wdata1 = wbase;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      oG0[c] = bus.grant0;  oG1[c] = bus.grant1;  oA0[c] = bus.ack0;  oA1[c] = bus.ack1;
      oV0[c] = bus.rvalid0; oV1[c] = bus.rvalid1; oD0[c] = bus.done0; oD1[c] = bus.done1;
      oWe[c] = bus.ramWriteEnable; oAd[c] = bus.ramAddress; oRd[c] = bus.rdata;
      @(posedge clock); #1;
      if (c + 1 >= holdCyc) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      if (who == 0 ? oA0[c] : oA1[c]) begin
        beat++;
        if (who == 0) bus.wdata0 = wbase + 32'(beat);
        else          bus.wdata1 = wbase + 32'(beat);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    logic [81:0] outs;
    bus.wdata0 = 32'hFFFF_FFFF; bus.wdata1 = 32'hFFFF_FFFF;
    repeat (2) @(negedge clock);
    outs = {bus.grant0, bus.grant1, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.done0,
            bus.done1, bus.rdata, bus.ramAddress, bus.ramWriteEnable, bus.ramDataIn};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    nReset = 1'b1;
    @(negedge clock);
    outs = {bus.grant0, bus.grant1, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.done0,
            bus.done1, bus.rdata, bus.ramAddress, bus.ramWriteEnable, bus.ramDataIn};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL idle_outs got=%h exp=0", outs); end
  endtask

  task automatic test_single_write();
    run_burst(0, 1'b1, 9'h010, 4'd3, 1, 32'hA5A5_0000, 8);
    for (int c = 0; c < 8; c++) begin
      logic inB;
      logic [8:0] expA;
      inB  = (c >= 1 && c <= 4);
      expA = (c == 0) ? 9'h000 : (inB ? 9'(9'h010 + c - 1) : 9'h013);
      checks++;
      if ({oG0[c], oG1[c], oA0[c], oA1[c], oWe[c], oD0[c], oV0[c]} !== {inB, 1'b0, inB, 1'b0, inB, c == 5, 1'b0}) begin
        failures++;
        $display("FAIL wr_ctrl cyc=%0d got=%b%b%b%b%b%b%b exp=%b0%b0%b%b0", c, oG0[c], oG1[c], oA0[c], oA1[c],
                 oWe[c], oD0[c], oV0[c], inB, inB, inB, c == 5);
      end
      checks++;
      if (oAd[c] !== expA) begin failures++; $display("FAIL wr_addr cyc=%0d got=%h exp=%h", c, oAd[c], expA); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[9'h010 + i] !== 32'hA5A5_0000 + 32'(i)) begin
        failures++; $display("FAIL wr_mem i=%0d got=%h exp=%h", i, mem[9'h010 + i], 32'hA5A5_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_read_back();
    run_burst(1, 1'b0, 9'h010, 4'd3, 1, 32'h0, 8);
    for (int c = 0; c < 8; c++) begin
      logic inB, rv;
      inB = (c >= 1 && c <= 4);
      rv  = (c >= 2 && c <= 5);
      checks++;
      if ({oG1[c], oG0[c], oA1[c], oWe[c], oV1[c], oV0[c], oD1[c]} !== {inB, 1'b0, 1'b0, 1'b0, rv, 1'b0, c == 5}) begin
        failures++;
        $display("FAIL rd_ctrl cyc=%0d got=%b%b%b%b%b%b%b exp=%b000%b0%b", c, oG1[c], oG0[c], oA1[c], oWe[c],
                 oV1[c], oV0[c], oD1[c], inB, rv, c == 5);
      end
      if (rv) begin
        checks++;
        if (oRd[c] !== 32'hA5A5_0000 + 32'(c - 2)) begin
          failures++; $display("FAIL rd_data cyc=%0d got=%h exp=%h", c, oRd[c], 32'hA5A5_0000 + 32'(c - 2));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [8:0] expA [4];
    expA = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    run_burst(0, 1'b1, 9'h1FE, 4'd3, 1, 32'h5A00_0000, 8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oAd[i + 1] !== expA[i] || oWe[i + 1] !== 1'b1) begin
        failures++; $display("FAIL wrap_addr beat=%0d got=%h/%b exp=%h/1", i, oAd[i + 1], oWe[i + 1], expA[i]);
      end
      checks++;
      if (mem[expA[i]] !== 32'h5A00_0000 + 32'(i)) begin
        failures++; $display("FAIL wrap_mem beat=%0d got=%h exp=%h", i, mem[expA[i]], 32'h5A00_0000 + 32'(i));
      end
    end
    checks++;
    if (oAd[5] !== 9'h001 || oWe[5] !== 1'b0) begin
      failures++; $display("FAIL wrap_hold got=%h/%b exp=001/0", oAd[5], oWe[5]);
    end
  endtask

  task automatic test_abort();
    int nd;
    nd = 0;
    run_burst(0, 1'b1, 9'h080, 4'd15, 2, 32'hC0DE_0000, 22);
    for (int c = 0; c < 22; c++) begin
      checks++;
      if (oG0[c] !== (c >= 1 && c <= 16)) begin
        failures++; $display("FAIL abort_grant cyc=%0d got=%b exp=%b", c, oG0[c], c >= 1 && c <= 16);
      end
      if (oD0[c]) nd++;
    end
    checks++;
    if (nd != 1 || oD0[17] !== 1'b1) begin
      failures++; $display("FAIL abort_done count=%0d at17=%b exp=1/1", nd, oD0[17]);
    end
    checks++;
    if (mem[9'h08F] !== 32'hC0DE_000F) begin
      failures++; $display("FAIL abort_mem got=%h exp=c0de000f", mem[9'h08F]);
    end
  endtask

  task automatic test_tie();
    @(posedge clock); #1; nReset = 1'b0;
    repeat (2) @(negedge clock);
    nReset = 1'b1;
    @(posedge clock); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 9'h010; bus.len0 = 4'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 9'h011; bus.len1 = 4'd0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      checks++;
      if ({bus.grant0, bus.grant1} !== {c == 1 || c == 7, c == 4 || c == 10}) begin
        failures++;
        $display("FAIL tie_grant cyc=%0d got=%b%b exp=%b%b", c, bus.grant0, bus.grant1, c == 1 || c == 7, c == 4 || c == 10);
      end
      if (c == 2) begin
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata !== 32'hA5A5_0000) begin
          failures++; $display("FAIL tie_rd0 got=%b/%h exp=1/a5a50000", bus.rvalid0, bus.rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata !== 32'hA5A5_0001) begin
          failures++; $display("FAIL tie_rd1 got=%b/%h exp=1/a5a50001", bus.rvalid1, bus.rdata);
        end
      end
      @(posedge clock); #1;
      if (c == 11) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [81:0] outs;
    int nd;
    nd = 0;
    @(posedge clock); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 9'h100; bus.len0 = 4'd15; bus.wdata0 = 32'h1111_0000;
    @(posedge clock); #1;
    bus.req0 = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (bus.grant0 !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", bus.grant0); end
    nReset = 1'b0;
    #1;
    outs = {bus.grant0, bus.grant1, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.done0,
            bus.done1, bus.rdata, bus.ramAddress, bus.ramWriteEnable, bus.ramDataIn};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL rst_mid_outs got=%h exp=0", outs); end
    repeat (3) begin @(negedge clock); if (bus.done0 || bus.done1) nd++; end
    nReset = 1'b1;
    repeat (20) begin @(negedge clock); if (bus.done0 || bus.done1 || bus.grant0 || bus.grant1) nd++; end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", nd); end
    run_burst(1, 1'b0, 9'h010, 4'd0, 1, 32'h0, 5);
    checks++;
    if ({oG1[0], oG1[1], oG1[2], oV1[2], oD1[2]} !== 5'b01011 || oRd[2] !== 32'hA5A5_0000) begin
      failures++;
      $display("FAIL rst_mid_after got=%b%b%b%b%b/%h exp=01011/a5a50000", oG1[0], oG1[1], oG1[2], oV1[2], oD1[2], oRd[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_wrap();
    test_abort();
    test_tie();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t exp=bench finished", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ssram_port_arbiter.md
SSRAM_PORT_ARBITER -- requirements
Module: ssram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, SSRAM word-address width (512 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SSRAM word width.
REQ-003 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port nReset  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  burst request, requester 0/1.
REQ-006 SHALL have ports we0/we1  input  1  burst direction, 1=write, 0=read.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_WIDTH  burst start word address.
REQ-008 SHALL have ports len0/len1  input  4  burst length minus one (1..16 beats).
REQ-009 SHALL have ports wdata0/wdata1  input  DATA_WIDTH  current write beat.
REQ-010 SHALL have ports grant0/grant1  output  1  requester owns RAM port this cycle.
REQ-011 SHALL have ports ack0/ack1  output  1  write beat consumed this cycle.
REQ-012 SHALL have ports rvalid0/rvalid1  output  1  rdata holds a read beat.
REQ-013 SHALL have port rdata  output  DATA_WIDTH  read data, shared by both requesters.
REQ-014 SHALL have ports done0/done1  output  1  one-cycle burst-complete pulse.
REQ-015 SHALL have ports ramAddress  output  ADDR_WIDTH, ramWriteEnable  output  1, ramDataIn  output  DATA_WIDTH: drive one SSRAM port.
REQ-016 SHALL have port ramDataOut  input  DATA_WIDTH  SSRAM registered read data (1-cycle latency).

Function
REQ-017 SHALL implement FSM states IDLE, BURST, DRAIN.
REQ-018 IDLE: when any req is high, SHALL latch winner, its we/addr/len into owner, addrCnt, beatCnt, dir, then go to BURST.
REQ-019 Arbitration SHALL be round-robin: single request wins; both high -> requester not in lastGrant wins; lastGrant updates on each award.
REQ-020 req/we/addr/len SHALL be sampled only in IDLE; changes or req deassertion during BURST/DRAIN SHALL NOT abort or alter the burst.
REQ-021 BURST: grantOwner=1, ramAddress=addrCnt, ramWriteEnable=dir, ramDataIn=wdataOwner (combinational mux); non-owner grant/ack/rvalid=0.
REQ-022 BURST write: ackOwner=1 every BURST cycle; requester SHALL present the next beat on wdata the cycle after each ack.
REQ-023 BURST read: rvalidOwner=1 and rdata=ramDataOut the cycle after each BURST cycle (including the first DRAIN cycle).
REQ-024 Each BURST cycle addrCnt SHALL increment modulo 2^ADDR_WIDTH (511 -> 0 wrap); beatCnt SHALL decrement.
REQ-025 When beatCnt==0 in BURST, next state SHALL be DRAIN; DRAIN lasts exactly one cycle, pulses doneOwner, then returns to IDLE.
REQ-026 Latency: req seen in IDLE cycle T -> grant and first RAM access at T+1, first rvalid at T+2, done at T+len+2, IDLE at T+len+3.
REQ-027 ramWriteEnable SHALL be 0 in IDLE and DRAIN; ramAddress SHALL hold its last value outside BURST.
REQ-028 At most one of grant0/grant1 SHALL be high in any cycle.

Reset
REQ-029 nReset low SHALL asynchronously force state=IDLE, lastGrant=1 (requester 0 wins first tie), addrCnt=0, beatCnt=0, dir=0.
REQ-030 During reset, all outputs SHALL be 0 (grant, ack, rvalid, done, rdata, ramAddress, ramWriteEnable, ramDataIn).
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no done pulse; after release the block SHALL arbitrate from IDLE.

Structure
REQ-032 State encodings (IDLE=2'd0, BURST=2'd1, DRAIN=2'd2) and default widths SHALL live in the shared package ssram_arbiter_pkg.
REQ-033 Round-robin selection SHALL be a sub-module ssram_rr_pick (inputs req0, req1, lastGrant; output winner, valid).

Verification
REQ-034 Reset: nReset low mid-burst -> all outputs 0 immediately, no done pulse; first request after release granted from IDLE.
REQ-035 Single write: req0, we0=1, addr0=0x010, len0=3 -> grant0 and ack0 for 4 cycles starting 1 cycle after req; RAM 0x010..0x013 written; done0 one cycle after last beat.
REQ-036 Read-back: req1, we1=0, addr1=0x010, len1=3 -> rvalid1 for 4 cycles starting 2 cycles after req, rdata equals the written words in order.
REQ-037 Tie: req0 and req1 both high from reset -> requester 0 served first, requester 1 next; repeated ties alternate 0,1,0,1.
REQ-038 Wrap: write addr=0x1FE, len=3 -> addresses 0x1FE, 0x1FF, 0x000, 0x001 written.
REQ-039 Abort attempt: req0 dropped after first beat of a 16-beat burst (len0=15) -> all 16 beats still executed, done0 pulses once.
